// File: rtl/pf_vf_route_lookup.sv
// Ingress route lookup ahead of the PF/VF MUX: resolves the destination port on each
// packet's first beat, tags every beat with it, and counts table misses.
module pf_vf_route_lookup #(
    parameter int DATA_W      = 512,
    parameter int PF_W        = 3,
    parameter int VF_W        = 11,
    parameter int PORT_W      = 4,
    parameter int NUM_ENTRIES = 8,
    parameter int MISS_PORT   = 0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_ENTRIES*(PF_W+VF_W+1+PORT_W)-1:0]    rtable_i,
    input  logic                                           i_valid,
    output logic                                           i_ready,
    input  logic [DATA_W-1:0]                              i_data,
    input  logic                                           i_last,
    input  logic [PF_W-1:0]                                i_pf,
    input  logic [VF_W-1:0]                                i_vf,
    input  logic                                           i_vf_active,
    output logic                                           o_valid,
    input  logic                                           o_ready,
    output logic [DATA_W-1:0]                              o_data,
    output logic                                           o_last,
    output logic [PORT_W-1:0]                              o_port,
    output logic                                           o_miss,
    input  logic                                           miss_cnt_clr,
    output logic [15:0]                                    miss_cnt,
    output logic                                           miss_sticky
);
    localparam int ENT_W = PF_W + VF_W + 1 + PORT_W;

    logic [NUM_ENTRIES-1:0] w_match;
    logic                   w_lk_hit;
    logic [PORT_W-1:0]      w_lk_port;
    logic                   w_accept, w_first, w_out_load, w_skid_full_nxt;
    logic [PORT_W-1:0]      w_port;
    logic                   w_miss;

    logic                   r_in_rdy, r_in_pkt, r_cur_miss, r_skid_full;
    logic [PORT_W-1:0]      r_cur_port;
    logic [DATA_W-1:0]      r_skid_data, r_o_data;
    logic                   r_skid_last, r_skid_miss, r_o_valid, r_o_last, r_o_miss;
    logic [PORT_W-1:0]      r_skid_port, r_o_port;
    logic [15:0]            r_miss_cnt;
    logic                   r_miss_sticky;

    genvar g;
    generate
        for (g = 0; g < NUM_ENTRIES; g++) begin : g_ent
            logic [PF_W-1:0] w_e_pf;
            logic [VF_W-1:0] w_e_vf;
            logic            w_e_va;
            assign w_e_pf = rtable_i[g*ENT_W +: PF_W];
            assign w_e_vf = rtable_i[g*ENT_W + PF_W +: VF_W];
            assign w_e_va = rtable_i[g*ENT_W + PF_W + VF_W];
            assign w_match[g] = (w_e_pf == i_pf) && (w_e_va == i_vf_active) &&
                                (!i_vf_active || (w_e_vf == i_vf));
        end
    endgenerate

    // Walk from the top down so the lowest matching index ends up winning.
    always_comb begin
        w_lk_hit  = 1'b0;
        w_lk_port = PORT_W'(MISS_PORT);
        for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_lk_hit  = 1'b1;
                w_lk_port = rtable_i[k*ENT_W + PF_W + VF_W + 1 +: PORT_W];
            end
        end
    end

    assign w_accept   = i_valid && r_in_rdy;
    assign w_first    = w_accept && !r_in_pkt;
    assign w_port     = r_in_pkt ? r_cur_port : w_lk_port;
    assign w_miss     = r_in_pkt ? r_cur_miss : !w_lk_hit;
    assign w_out_load = !r_o_valid || o_ready;
    // Skid only ever fills while the output is stalled; any output load drains it.
    assign w_skid_full_nxt = w_out_load ? 1'b0 : (r_skid_full || w_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_rdy    <= 1'b0;
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
            r_skid_port <= '0;
            r_skid_miss <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_data    <= '0;
            r_o_last    <= 1'b0;
            r_o_port    <= '0;
            r_o_miss    <= 1'b0;
        end else begin
            r_in_rdy    <= !w_skid_full_nxt;
            r_skid_full <= w_skid_full_nxt;
            if (w_out_load) begin
                if (r_skid_full) begin
                    r_o_valid <= 1'b1;
                    r_o_data  <= r_skid_data;
                    r_o_last  <= r_skid_last;
                    r_o_port  <= r_skid_port;
                    r_o_miss  <= r_skid_miss;
                end else if (w_accept) begin
                    r_o_valid <= 1'b1;
                    r_o_data  <= i_data;
                    r_o_last  <= i_last;
                    r_o_port  <= w_port;
                    r_o_miss  <= w_miss;
                end else begin
                    r_o_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_data <= i_data;
                r_skid_last <= i_last;
                r_skid_port <= w_port;
                r_skid_miss <= w_miss;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_pkt      <= 1'b0;
            r_cur_port    <= '0;
            r_cur_miss    <= 1'b0;
            r_miss_cnt    <= '0;
            r_miss_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_pkt <= !i_last;
                if (!r_in_pkt) begin
                    r_cur_port <= w_lk_port;
                    r_cur_miss <= !w_lk_hit;
                end
            end
            if (miss_cnt_clr) begin
                r_miss_cnt    <= '0;
                r_miss_sticky <= 1'b0;
            end else if (w_first && !w_lk_hit) begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
                r_miss_sticky <= 1'b1;
            end
        end
    end

    assign i_ready     = r_in_rdy;
    assign o_valid     = r_o_valid;
    assign o_data      = r_o_data;
    assign o_last      = r_o_last;
    assign o_port      = r_o_port;
    assign o_miss      = r_o_miss;
    assign miss_cnt    = r_miss_cnt;
    assign miss_sticky = r_miss_sticky;
endmodule

// File: tb/tb_pf_vf_route_lookup.sv
// Scoreboard bench for pf_vf_route_lookup: expected beats queued at accept, checked at output.
module tb_pf_vf_route_lookup;
    localparam int DATA_W = 512, PF_W = 3, VF_W = 11, PORT_W = 4, NE = 8;
    localparam int ENT_W = PF_W + VF_W + 1 + PORT_W;

    logic clk, rst_n;
    logic [NE*ENT_W-1:0] rtable;
    logic i_valid, i_ready, i_last, i_vf_active, o_valid, o_ready, o_last, o_miss;
    logic [DATA_W-1:0] i_data, o_data;
    logic [PF_W-1:0] i_pf;
    logic [VF_W-1:0] i_vf;
    logic [PORT_W-1:0] o_port;
    logic miss_cnt_clr, miss_sticky;
    logic [15:0] miss_cnt;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [PORT_W-1:0] port;
        logic              miss;
        int                acc_cyc;
        bit                chk_lat;
    } exp_t;
    exp_t sbq[$];

    int n_chk = 0, n_pass = 0, cyc = 0;
    bit sb_en = 1;

    pf_vf_route_lookup #(.DATA_W(DATA_W), .PF_W(PF_W), .VF_W(VF_W), .PORT_W(PORT_W),
                         .NUM_ENTRIES(NE), .MISS_PORT(0)) dut (
        .clk(clk), .rst_n(rst_n), .rtable_i(rtable),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
        .i_pf(i_pf), .i_vf(i_vf), .i_vf_active(i_vf_active),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
        .o_port(o_port), .o_miss(o_miss),
        .miss_cnt_clr(miss_cnt_clr), .miss_cnt(miss_cnt), .miss_sticky(miss_sticky));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on each transfer and checks hold stability.
    initial begin
        bit hold = 0;
        logic [DATA_W-1:0] h_data;
        logic h_last, h_miss;
        logic [PORT_W-1:0] h_port;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) hold = 0;
            else begin
                if (hold) begin
                    n_chk++;
                    if (o_valid !== 1'b1 || o_data !== h_data || o_port !== h_port ||
                        o_last !== h_last || o_miss !== h_miss)
                        $display("FAIL stall_stable: got v=%b port=%0d last=%b miss=%b d=%h want v=1 port=%0d last=%b miss=%b d=%h",
                                 o_valid, o_port, o_last, o_miss, o_data[31:0], h_port, h_last, h_miss, h_data[31:0]);
                    else n_pass++;
                end
                if (o_valid === 1'b1 && o_ready && sb_en) begin
                    n_chk++;
                    if (sbq.size() == 0) begin
                        $display("FAIL unexpected_beat: got d=%h port=%0d want no beat", o_data[31:0], o_port);
                    end else begin
                        e = sbq.pop_front();
                        if (o_data !== e.data || o_last !== e.last || o_port !== e.port ||
                            o_miss !== e.miss || (e.chk_lat && cyc != e.acc_cyc))
                            $display("FAIL out_beat: got d=%h last=%b port=%0d miss=%b cyc=%0d want d=%h last=%b port=%0d miss=%b cyc=%0d",
                                     o_data[31:0], o_last, o_port, o_miss, cyc,
                                     e.data[31:0], e.last, e.port, e.miss, e.acc_cyc);
                        else n_pass++;
                    end
                end
                hold   = (o_valid === 1'b1) && !o_ready;
                h_data = o_data; h_last = o_last; h_port = o_port; h_miss = o_miss;
            end
        end
    end

    task automatic set_entry(input int k, input logic [PF_W-1:0] pf, input logic [VF_W-1:0] vf,
                             input logic va, input logic [PORT_W-1:0] port);
        rtable[k*ENT_W +: ENT_W] = {port, va, vf, pf};
    endtask

    task automatic send_beat(input int tag, input logic last, input logic [PF_W-1:0] pf,
                             input logic [VF_W-1:0] vf, input logic va,
                             input logic [PORT_W-1:0] eport, input logic emiss, input bit chk_lat);
        bit acc = 0;
        exp_t e;
        i_valid = 1'b1; i_data = {16{tag}}; i_last = last;
        i_pf = pf; i_vf = vf; i_vf_active = va;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = i_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL accept_timeout: got i_ready=0 for 200 cycles want accept (tag %0d)", tag);
        end else if (sb_en) begin
            e.data = {16{tag}}; e.last = last; e.port = eport; e.miss = emiss;
            e.acc_cyc = cyc; e.chk_lat = chk_lat;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 100 && sbq.size() != 0; n++) @(posedge clk);
        #1;
        n_chk++;
        if (sbq.size() != 0) $display("FAIL %s_drain: got %0d beats pending want 0", name, sbq.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; o_ready = 1'b1; miss_cnt_clr = 1'b0; idle();
        i_data = '0; i_pf = '0; i_vf = '0; i_vf_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (i_ready !== 1'b0 || o_valid !== 1'b0 || o_last !== 1'b0 || o_port !== '0 ||
            o_miss !== 1'b0 || o_data !== '0 || miss_cnt !== 16'd0 || miss_sticky !== 1'b0)
            $display("FAIL reset_state: got rdy=%b v=%b last=%b port=%0d miss=%b cnt=%0d sticky=%b want all 0",
                     i_ready, o_valid, o_last, o_port, o_miss, miss_cnt, miss_sticky);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (i_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", i_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        send_beat(1, 1, 3'd1, 11'd0, 1'b0, 4'd1, 1'b0, 1);
        send_beat(2, 1, 3'd2, 11'd0, 1'b0, 4'd2, 1'b0, 1);
        send_beat(3, 1, 3'd0, 11'd3, 1'b1, 4'd7, 1'b0, 1);
        idle();
        wait_drain("single");
    endtask

    task automatic test_multi();
        send_beat(10, 0, 3'd0, 11'd3, 1'b1, 4'd7, 1'b0, 0);
        for (int j = 1; j < 4; j++) send_beat(10 + j, j == 3, 3'd2, 11'd0, 1'b0, 4'd7, 1'b0, 0);
        idle();
        wait_drain("multi");
        n_chk++;
        if (miss_cnt !== 16'd0 || miss_sticky !== 1'b0)
            $display("FAIL multi_nomiss: got cnt=%0d sticky=%b want 0 0", miss_cnt, miss_sticky);
        else n_pass++;
    endtask

    task automatic test_miss();
        for (int j = 0; j < 3; j++) send_beat(20 + j, j == 2, 3'd5, 11'd0, 1'b0, 4'd0, 1'b1, 0);
        idle();
        wait_drain("miss");
        n_chk++;
        if (miss_cnt !== 16'd1 || miss_sticky !== 1'b1)
            $display("FAIL miss_count: got cnt=%0d sticky=%b want 1 1", miss_cnt, miss_sticky);
        else n_pass++;
        miss_cnt_clr = 1'b1;
        send_beat(23, 1, 3'd5, 11'd0, 1'b0, 4'd0, 1'b1, 0);
        miss_cnt_clr = 1'b0;
        idle();
        wait_drain("miss_clr");
        n_chk++;
        if (miss_cnt !== 16'd0 || miss_sticky !== 1'b0)
            $display("FAIL miss_clr_wins: got cnt=%0d sticky=%b want 0 0", miss_cnt, miss_sticky);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit done = 0, saw_stall = 0;
        logic [PF_W-1:0] fpf[4] = '{3'd1, 3'd0, 3'd5, 3'd2};
        logic [VF_W-1:0] fvf[4] = '{11'd0, 11'd3, 11'd0, 11'd0};
        logic fva[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [PORT_W-1:0] eport[4] = '{4'd1, 4'd7, 4'd0, 4'd2};
        logic emiss[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        fork
            begin
                for (int p = 0; p < 4; p++)
                    for (int j = 0; j < 5; j++)
                        if (j == 0) send_beat(100 + p*5, 0, fpf[p], fvf[p], fva[p], eport[p], emiss[p], 0);
                        else send_beat(100 + p*5 + j, j == 4, 3'd1, 11'd0, 1'b0, eport[p], emiss[p], 0);
                idle();
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    o_ready = ~o_ready;
                    if (!i_ready) saw_stall = 1;
                end
            end
        join
        o_ready = 1'b1;
        wait_drain("b2b");
        n_chk++;
        if (!saw_stall) $display("FAIL b2b_backpressure: got i_ready never low want skid-full stall");
        else n_pass++;
        n_chk++;
        if (miss_cnt !== 16'd1) $display("FAIL b2b_miss_cnt: got %0d want 1", miss_cnt);
        else n_pass++;
    endtask

    task automatic test_dup_and_table_change();
        set_entry(4, 3'd1, 11'd0, 1'b0, 4'd5);
        send_beat(200, 1, 3'd1, 11'd0, 1'b0, 4'd1, 1'b0, 0);
        send_beat(201, 0, 3'd2, 11'd0, 1'b0, 4'd2, 1'b0, 0);
        set_entry(2, 3'd2, 11'd0, 1'b0, 4'd9);
        send_beat(202, 1, 3'd2, 11'd0, 1'b0, 4'd2, 1'b0, 0);
        send_beat(203, 1, 3'd2, 11'd0, 1'b0, 4'd9, 1'b0, 0);
        idle();
        wait_drain("dup");
    endtask

    task automatic test_saturate();
        miss_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        miss_cnt_clr = 1'b0;
        sb_en = 0;
        for (int n = 0; n < 16'hFFFE; n++) send_beat(n, 1, 3'd5, 11'd0, 1'b0, 4'd0, 1'b1, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        sb_en = 1;
        n_chk++;
        if (miss_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h want fffe", miss_cnt);
        else n_pass++;
        for (int j = 0; j < 3; j++) send_beat(300 + j, 1, 3'd5, 11'd0, 1'b0, 4'd0, 1'b1, 0);
        idle();
        wait_drain("sat");
        n_chk++;
        if (miss_cnt !== 16'hFFFF || miss_sticky !== 1'b1)
            $display("FAIL sat_count: got cnt=%h sticky=%b want ffff 1", miss_cnt, miss_sticky);
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        o_ready = 1'b0;
        send_beat(400, 0, 3'd0, 11'd3, 1'b1, 4'd7, 1'b0, 0);
        send_beat(401, 0, 3'd0, 11'd3, 1'b1, 4'd7, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        sbq.delete();
        idle();
        n_chk++;
        if (o_valid !== 1'b0 || i_ready !== 1'b0 || miss_cnt !== 16'd0)
            $display("FAIL midreset_state: got v=%b rdy=%b cnt=%0d want 0 0 0", o_valid, i_ready, miss_cnt);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        send_beat(402, 1, 3'd1, 11'd0, 1'b0, 4'd1, 1'b0, 1);
        idle();
        wait_drain("midreset");
    endtask

    initial begin
        rtable = '0;
        for (int k = 0; k < NE; k++) set_entry(k, 3'd7, 11'h7FF, 1'b1, 4'd15);
        set_entry(0, 3'd0, 11'd0, 1'b0, 4'd0);
        set_entry(1, 3'd1, 11'd0, 1'b0, 4'd1);
        set_entry(2, 3'd2, 11'd0, 1'b0, 4'd2);
        set_entry(3, 3'd0, 11'd3, 1'b1, 4'd7);
        test_reset();
        test_single();
        test_multi();
        test_miss();
        test_back_to_back();
        test_dup_and_table_change();
        test_saturate();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
